// File: rtl/led_ctrl.sv
// led_ctrl: NCH-channel LED driver; each channel is off/on/follow/blink/stretch/pwm, set through a write port.
// Latency: led/busy are registered and show channel state one sys_clk edge later.
// Backpressure: none; a config write lands in one cycle, and writes to channels >= NCH are dropped.
module led_ctrl #(
  parameter int NCH       = 8,
  parameter int PRESC_DIV = 1_000_000,
  parameter int TCNT_W    = 16,
  parameter int ARG_W     = 8,
  parameter int PWM_W     = 4
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [NCH-1:0]         evt,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [2:0]             cfg_mode,
  input  logic [ARG_W-1:0]       cfg_arg,
  output logic [NCH-1:0]         led,
  output logic [NCH-1:0]         busy
);

  localparam int CH_W = $clog2(NCH);
  localparam int PR_W = $clog2(PRESC_DIV);
  localparam int BI_W = $clog2(TCNT_W);

  localparam logic [2:0] MODE_OFF     = 3'd0;
  localparam logic [2:0] MODE_ON      = 3'd1;
  localparam logic [2:0] MODE_FOLLOW  = 3'd2;
  localparam logic [2:0] MODE_BLINK   = 3'd3;
  localparam logic [2:0] MODE_STRETCH = 3'd4;
  localparam logic [2:0] MODE_PWM     = 3'd5;

  logic [PR_W-1:0]   presc;
  logic              tick;
  logic [TCNT_W-1:0] tcnt;
  logic [PWM_W-1:0]  pwm_ph;
  logic [NCH-1:0]    evt_q;
  logic [NCH-1:0]    rise;
  logic [NCH-1:0]    ch_wr;
  logic [2:0]        mode [NCH];
  logic [ARG_W-1:0]  arg  [NCH];
  logic [ARG_W-1:0]  scnt [NCH];
  logic [NCH-1:0]    led_d;
  logic [NCH-1:0]    busy_d;
  logic [BI_W-1:0]   bidx;

  assign tick = (presc == PR_W'(PRESC_DIV - 1));
  assign rise = evt & ~evt_q;

  // Decode the write strobe per channel; channel numbers >= NCH match nothing.
  always_comb begin
    ch_wr = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_wr[i] = cfg_we && (cfg_ch == CH_W'(i));
    end
  end

  // Shared timebase: prescaler, tick counter and free-running PWM phase.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      presc  <= '0;
      tcnt   <= '0;
      pwm_ph <= '0;
    end else begin
      presc  <= tick ? '0 : presc + PR_W'(1);
      pwm_ph <= pwm_ph + PWM_W'(1);
      if (tick) begin
        tcnt <= tcnt + TCNT_W'(1);
      end
    end
  end

  // Per-channel config and stretch counters; a write clears the counter and
  // beats a rise in the same cycle, and a rise reload beats a tick decrement.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      evt_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        mode[i] <= MODE_OFF;
        arg[i]  <= '0;
        scnt[i] <= '0;
      end
    end else begin
      evt_q <= evt;
      for (int i = 0; i < NCH; i++) begin
        if (ch_wr[i]) begin
          mode[i] <= cfg_mode;
          arg[i]  <= cfg_arg;
          scnt[i] <= '0;
        end else if (mode[i] != MODE_STRETCH) begin
          scnt[i] <= '0;
        end else if (rise[i]) begin
          scnt[i] <= (arg[i] == '0) ? ARG_W'(1) : arg[i];
        end else if (tick && (scnt[i] != '0)) begin
          scnt[i] <= scnt[i] - ARG_W'(1);
        end
      end
    end
  end

  // Next LED/busy value from the current mode; blink bit index saturates at the counter MSB.
  always_comb begin
    led_d  = '0;
    busy_d = '0;
    bidx   = '0;
    for (int i = 0; i < NCH; i++) begin
      busy_d[i] = |scnt[i];
      bidx = (arg[i] >= ARG_W'(TCNT_W - 1)) ? BI_W'(TCNT_W - 1) : BI_W'(arg[i]);
      case (mode[i])
        MODE_ON:      led_d[i] = 1'b1;
        MODE_FOLLOW:  led_d[i] = evt_q[i];
        MODE_BLINK:   led_d[i] = tcnt[bidx];
        MODE_STRETCH: led_d[i] = |scnt[i];
        MODE_PWM:     led_d[i] = (pwm_ph < arg[i][PWM_W-1:0]);
        default:      led_d[i] = 1'b0;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      led  <= '0;
      busy <= '0;
    end else begin
      led  <= led_d;
      busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: directed test of led_ctrl with NCH=6 (3-bit cfg_ch, so channels 6 and 7 are out of range),
// PRESC_DIV=4, TCNT_W=16, ARG_W=8, PWM_W=4. After reset release, edge e ticks when e%4==0,
// tcnt = e/4 and pwm_ph = e%16; led after edge n reflects state after edge n-1.
module tb_led_ctrl;

  localparam int NCH = 6;

  logic           sys_clk = 1'b0;
  logic           sys_rst;
  logic [NCH-1:0] evt;
  logic           cfg_we;
  logic [2:0]     cfg_ch;
  logic [2:0]     cfg_mode;
  logic [7:0]     cfg_arg;
  logic [NCH-1:0] led;
  logic [NCH-1:0] busy;

  int n_chk  = 0;
  int n_pass = 0;
  int n      = 0;  // edges since the last reset release

  led_ctrl #(.NCH(NCH), .PRESC_DIV(4), .TCNT_W(16), .ARG_W(8), .PWM_W(4)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .evt      (evt),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_arg  (cfg_arg),
    .led      (led),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", tag, got, exp, n);
  endtask

  // Advance k rising edges, returning at the following falling edge.
  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge sys_clk);
      n++;
      @(negedge sys_clk);
    end
  endtask

  task automatic cfg_write(input logic [2:0] ch, input logic [2:0] md, input logic [7:0] a);
    cfg_we   = 1'b1;
    cfg_ch   = ch;
    cfg_mode = md;
    cfg_arg  = a;
    step(1);
    cfg_we   = 1'b0;
  endtask

  // Stop when the next edge is one right after a tick edge (next edge % 4 == 1).
  task automatic align();
    while (n % 4 != 0) step(1);
  endtask

  // One-cycle evt[ch] pulse sampled at the next edge.
  task automatic pulse(input int ch);
    evt[ch] = 1'b1;
    step(1);
    evt[ch] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    sys_rst = 1'b1; evt = '0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_arg = '0;
    @(negedge sys_clk);
    step(3);
    check("rst_led", 32'(led), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    sys_rst = 1'b0;
    n = 0;

    // Idle for 100 cycles: outputs stay dark, tcnt reaches 25.
    for (int i = 0; i < 100; i++) begin
      step(1);
      check("idle", 32'({busy, led}), 32'd0);
    end
    check("tcnt100", 32'(dut.tcnt), 32'd25);

    // Out-of-range writes change nothing.
    cfg_write(3'd6, 3'd1, 8'd0);
    cfg_write(3'd7, 3'd1, 8'd0);
    step(2);
    check("oor_led", 32'(led), 32'd0);

    // BLINK: ch0 arg=1 follows tcnt[1]; ch1 arg=40 clamps to tcnt[15] (zero here).
    cfg_write(3'd0, 3'd3, 8'd1);
    cfg_write(3'd1, 3'd3, 8'd40);
    for (int i = 0; i < 32; i++) begin
      step(1);
      check("blink0", 32'(led[0]), 32'((((n - 1) / 4) >> 1) & 1));
      check("blink1", 32'(led[1]), 32'd0);
    end

    // STRETCH arg=3, pulse sampled at edge k (k%4==1): ticks at k+3,k+7,k+11.
    cfg_write(3'd2, 3'd4, 8'd3);
    align();
    pulse(2);
    check("str_k", 32'(led[2]), 32'd0);
    step(1);
    check("str_k1_led", 32'(led[2]), 32'd1);
    check("str_k1_busy", 32'(busy[2]), 32'd1);
    step(10);
    check("str_k11", 32'(led[2]), 32'd1);
    step(1);
    check("str_k12_led", 32'(led[2]), 32'd0);
    check("str_k12_busy", 32'(busy[2]), 32'd0);

    // Retrigger at k+4 reloads 3: ticks k+7,k+11,k+15, led low from k+16.
    align();
    pulse(2);
    step(3);
    pulse(2);
    step(8);
    check("retrig_k12", 32'(led[2]), 32'd1);
    step(3);
    check("retrig_k15", 32'(led[2]), 32'd1);
    step(1);
    check("retrig_k16", 32'(led[2]), 32'd0);

    // arg=0 acts as 1: tick at k+3 ends it, led low from k+4.
    cfg_write(3'd2, 3'd4, 8'd0);
    align();
    pulse(2);
    step(1);
    check("arg0_k1", 32'(led[2]), 32'd1);
    step(2);
    check("arg0_k3", 32'(led[2]), 32'd1);
    step(1);
    check("arg0_k4", 32'(led[2]), 32'd0);

    // Rewrite mid-stretch with a coincident rise: counter clears, rise is dropped.
    cfg_write(3'd2, 3'd4, 8'd3);
    align();
    pulse(2);
    step(1);
    check("rew_k1_busy", 32'(busy[2]), 32'd1);
    evt[2] = 1'b1;
    cfg_write(3'd2, 3'd4, 8'd3);
    check("rew_k2_busy", 32'(busy[2]), 32'd1);
    step(1);
    check("rew_k3_busy", 32'(busy[2]), 32'd0);
    step(3);
    check("rew_k6_busy", 32'(busy[2]), 32'd0);
    check("rew_k6_led", 32'(led[2]), 32'd0);
    evt[2] = 1'b0;

    // PWM duty arg/16 against phase (n-1)%16.
    cfg_write(3'd3, 3'd5, 8'd4);
    for (int i = 0; i < 16; i++) begin
      step(1);
      check("pwm4", 32'(led[3]), 32'(((n - 1) % 16) < 4));
    end
    cfg_write(3'd3, 3'd5, 8'd0);
    for (int i = 0; i < 16; i++) begin
      step(1);
      check("pwm0", 32'(led[3]), 32'd0);
    end
    cfg_write(3'd3, 3'd5, 8'd15);
    for (int i = 0; i < 16; i++) begin
      step(1);
      check("pwm15", 32'(led[3]), 32'(((n - 1) % 16) < 15));
    end

    // ON, reserved mode, FOLLOW.
    cfg_write(3'd4, 3'd1, 8'd0);
    step(1);
    check("on", 32'(led[4]), 32'd1);
    cfg_write(3'd4, 3'd6, 8'd0);
    step(1);
    check("mode6", 32'(led[4]), 32'd0);
    cfg_write(3'd5, 3'd2, 8'd0);
    evt[5] = 1'b1;
    step(1);
    check("fol_k", 32'(led[5]), 32'd0);
    step(1);
    check("fol_k1", 32'(led[5]), 32'd1);
    evt[5] = 1'b0;
    step(1);
    check("fol_k2", 32'(led[5]), 32'd1);
    step(1);
    check("fol_k3", 32'(led[5]), 32'd0);

    // Reset during active blink/stretch/pwm/on: everything goes dark and stays dark.
    cfg_write(3'd4, 3'd1, 8'd0);
    cfg_write(3'd2, 3'd4, 8'd3);
    align();
    pulse(2);
    step(1);
    check("pre_rst_busy", 32'(busy[2]), 32'd1);
    sys_rst = 1'b1;
    step(1);
    sys_rst = 1'b0;
    n = 0;
    check("mid_rst_out", 32'({busy, led}), 32'd0);
    check("mid_rst_tcnt", 32'(dut.tcnt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("post_rst", 32'({busy, led}), 32'd0);
    end
    cfg_write(3'd4, 3'd1, 8'd0);
    step(1);
    check("relight", 32'(led), 32'h10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
